// File: rtl/lipsi_fetch_if.sv
// Fetch-unit bundle: control-unit handshake plus the byte-memory read port.
// master = fetch unit (drives the request and the instruction outputs),
// slave  = environment (control unit and memory).
interface lipsi_fetch_if #(
  parameter int PC_W = 8
);
  // control unit side
  logic            advance;
  logic [1:0]      nxt_sel;
  logic [PC_W-1:0] acc;
  logic [7:0]      instruction;
  logic [7:0]      operand;
  logic            instr_valid;
  logic [PC_W-1:0] pc;
  logic            halted;
  logic            bus_err;
  // memory read port
  logic [7:0]      mem_rdata;
  logic            mem_rvalid;
  logic            mem_rreq;
  logic [PC_W-1:0] mem_raddr;

  modport master (
    input  advance, nxt_sel, acc, mem_rdata, mem_rvalid,
    output mem_rreq, mem_raddr, instruction, operand, instr_valid,
           pc, halted, bus_err
  );

  modport slave (
    output advance, nxt_sel, acc, mem_rdata, mem_rvalid,
    input  mem_rreq, mem_raddr, instruction, operand, instr_valid,
           pc, halted, bus_err
  );
endinterface

// File: rtl/lipsi_fetch_unit.sv
// Lipsi instruction fetch: owns the PC, fetches 1- or 2-byte instructions over a req/valid port.
// Latency: 2 cycles per byte with a zero-wait memory (1-byte valid at cycle 2, 2-byte at cycle 4).
// Backpressure: READY holds instruction/operand/pc until advance; a silent memory ends in HALT with bus_err.
module lipsi_fetch_unit #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              MAX_WAIT = 15
) (
  input logic           clk,
  input logic           reset,
  lipsi_fetch_if.master bus
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    IREQ,
    IWAIT,
    OREQ,
    OWAIT,
    READY,
    HALT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // A response in the same cycle as our own request is too early to be ours.
  logic rsp_ok;
  assign rsp_ok = bus.mem_rvalid && !bus.mem_rreq;

  // Length decode of the byte arriving now and of the held instruction.
  logic fetched_two;
  logic cur_two;
  assign fetched_two = (bus.mem_rdata[7:4] == 4'hC) || (bus.mem_rdata[7:4] == 4'hD);
  assign cur_two     = (bus.instruction[7:4] == 4'hC) || (bus.instruction[7:4] == 4'hD);

  // Last waiting cycle before the memory is declared dead.
  logic wait_last;
  assign wait_last = (wait_cnt == CNT_W'(MAX_WAIT - 1));

  // Fetch sequencer: all outputs are registered here, request is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IREQ;
      wait_cnt        <= '0;
      bus.pc          <= RESET_PC;
      bus.mem_raddr   <= RESET_PC;
      bus.mem_rreq    <= 1'b0;
      bus.instruction <= 8'h00;
      bus.operand     <= 8'h00;
      bus.instr_valid <= 1'b0;
      bus.halted      <= 1'b0;
      bus.bus_err     <= 1'b0;
    end else begin
      bus.mem_rreq <= 1'b0;
      case (state)
        IREQ: begin
          bus.mem_rreq  <= 1'b1;
          bus.mem_raddr <= bus.pc;
          wait_cnt      <= '0;
          state         <= IWAIT;
        end
        IWAIT: begin
          if (rsp_ok) begin
            bus.instruction <= bus.mem_rdata;
            if (fetched_two) begin
              // Issue the operand request straight away so it overlaps the decode.
              bus.mem_rreq  <= 1'b1;
              bus.mem_raddr <= bus.pc + PC_W'(1);
              wait_cnt      <= '0;
              state         <= OREQ;
            end else begin
              bus.operand     <= 8'h00;
              bus.instr_valid <= 1'b1;
              state           <= READY;
            end
          end else if (!bus.mem_rreq) begin
            // The request cycle itself is not counted as waiting.
            if (wait_last) begin
              bus.bus_err <= 1'b1;
              bus.halted  <= 1'b1;
              state       <= HALT;
            end else begin
              wait_cnt <= wait_cnt + CNT_W'(1);
            end
          end
        end
        OREQ: begin
          wait_cnt <= '0;
          state    <= OWAIT;
        end
        OWAIT: begin
          if (rsp_ok) begin
            bus.operand     <= bus.mem_rdata;
            bus.instr_valid <= 1'b1;
            state           <= READY;
          end else if (wait_last) begin
            bus.bus_err <= 1'b1;
            bus.halted  <= 1'b1;
            state       <= HALT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        READY: begin
          if (bus.advance) begin
            bus.instr_valid <= 1'b0;
            state           <= IREQ;
            case (bus.nxt_sel)
              2'b00: bus.pc <= bus.pc + (cur_two ? PC_W'(2) : PC_W'(1));
              2'b01: bus.pc <= PC_W'(bus.operand);
              2'b10: bus.pc <= bus.acc;
              default: begin
                bus.halted <= 1'b1;
                state      <= HALT;
              end
            endcase
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IREQ;
        end
      endcase
    end
  end

endmodule

// File: doc/lipsi_fetch_unit.md
Name: lipsi_fetch_unit

Overview:
- Instruction-fetch front end of the Lipsi processor; sits directly upstream of the control unit.
- Owns the program counter and fetches instructions from a variable-latency byte memory through a req/valid read port.
- Decodes only the instruction length: one or two bytes, operand byte fetched automatically.
- Presents a stable instruction and operand pair with a valid flag, and computes the next PC when the control unit signals advance.

Parameters:
- PC_W, 8, width of PC and memory address.
- RESET_PC, 0, PC value after reset.
- MAX_WAIT, 15, maximum cycles to wait for mem_rvalid before a bus error is declared.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- advance  in  1  control unit has consumed the current instruction; sampled only in READY.
- nxt_sel  in  2  next-PC select, qualified by advance: 00 sequential, 01 branch to operand, 10 jump to acc, 11 halt.
- acc  in  PC_W  accumulator value, used as the target for nxt_sel=10.
- mem_rdata  in  8  memory read data, valid when mem_rvalid is high.
- mem_rvalid  in  1  read-data-valid strobe from memory.
- mem_rreq  out  1  one-cycle read request pulse.
- mem_raddr  out  PC_W  read address, stable from the request until rvalid.
- instruction  out  8  current instruction byte.
- operand  out  8  second byte of a two-byte instruction, else 0x00.
- instr_valid  out  1  instruction and operand are valid.
- pc  out  PC_W  address of the current instruction.
- halted  out  1  fetch stopped, either by halt or by bus error.
- bus_err  out  1  sticky memory timeout flag.

Behaviour:
- Reset: synchronous and dominant in every state. All outputs are registered.
  - pc=RESET_PC, mem_raddr=RESET_PC.
  - instruction=0x00, operand=0x00.
  - instr_valid=0, mem_rreq=0, halted=0, bus_err=0.
  - Wait counter=0; state=IREQ.
- The memory shares this reset and drops any pending read. A mid-wait reset restarts the fetch at RESET_PC.
- Two-byte instructions are those with instruction[7:4] = 1100 (ALU immediate) or 1101 (branch). All others are one byte.
- States:
  - IREQ: mem_rreq=1 and mem_raddr=pc for exactly one cycle, then go to IWAIT.
  - IWAIT: when mem_rvalid=1, latch mem_rdata into instruction. If the instruction is two-byte, go to OREQ; otherwise clear operand and go to READY.
  - OREQ: mem_rreq=1 and mem_raddr=pc+1 (mod 2^PC_W) for one cycle, then go to OWAIT.
  - OWAIT: when mem_rvalid=1, latch operand and go to READY.
  - READY: instr_valid=1. On advance, drop instr_valid in the next cycle, update pc and go to IREQ:
    - 00: pc+1 for a one-byte instruction, pc+2 for a two-byte instruction.
    - 01: pc=operand[PC_W-1:0].
    - 10: pc=acc.
    - 11: pc unchanged, halted=1, go to HALT instead of IREQ.
  - HALT: terminal; only reset leaves it. instr_valid=0, mem_rreq=0.
- Signal rules:
  - advance outside READY is ignored.
  - mem_rvalid outside IWAIT and OWAIT is ignored.
  - mem_rvalid arriving in the same cycle as mem_rreq is ignored; the earliest valid response is the cycle after the request.
- Timing: zero-wait memory (rvalid one cycle after req) gives 2 cycles per fetched byte. From reset release, a one-byte instruction is valid at cycle 2 and a two-byte instruction at cycle 4.
- Timeout: the wait counter resets on entry to IWAIT or OWAIT and increments each cycle without rvalid. When it reaches MAX_WAIT, set bus_err=1 and halted=1, go to HALT, and hold instr_valid=0.
- Arithmetic: all PC arithmetic is modulo 2^PC_W. 0xFF+1=0x00, 0xFF+2=0x01, and the operand fetch at pc=0xFF reads address 0x00.
- Outputs instruction, operand and pc stay stable for the whole READY dwell, regardless of how long advance is delayed.

Test Plan:
- Reset, then memory returns 0x21 at addr 0 with zero wait -> mem_rreq pulses in cycle 0 with addr 0x00; instr_valid=1 from cycle 2 with instruction=0x21, operand=0x00, pc=0x00; advance with nxt_sel=00 -> next request at addr 0x01.
- Two-byte 0xC1 at 0x10 with operand 0x05 -> requests at 0x10 then 0x11, operand=0x05 in READY; advance with 00 -> pc=0x12.
- Branch 0xD0 with operand 0x40, advance with 01 -> pc=0x40 and a request at 0x40; with acc=0x7A, advance with 10 -> pc=0x7A.
- Wrap-around: two-byte instruction at 0xFF -> operand read from 0x00; advance with 00 -> pc=0x01.
- mem_rvalid withheld for MAX_WAIT=15 cycles -> bus_err=1 and halted=1, with no further mem_rreq until reset; a stray rvalid in READY or HALT is ignored.
- nxt_sel=11 -> halted=1 and instr_valid=0, advance ignored thereafter. Then assert reset mid-OWAIT on a later run -> state IREQ at RESET_PC and all outputs at their reset values.
